// File: rtl/arith_pkg.sv
// Shared types and widths for the arith_unit sequencer/arbiter.
package arith_pkg;
   localparam int OPW  = 3;
   localparam int DW   = 16;
   localparam int RW   = 32;
   localparam int NREQ = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/arith_arbiter_rr_arb2.sv
// Combinational 2-way round-robin grant; the side not granted last wins a tie.
module rr_arb2
   import arith_pkg::*;
(
   input  logic [NREQ-1:0] req_valid,
   input  logic            last_grant,
   output logic [NREQ-1:0] grant,
   output logic            gidx
);
   always_comb begin
      gidx = 1'b0;
      if (&req_valid) gidx = ~last_grant;
      else if (req_valid[1]) gidx = 1'b1;
      grant = '0;
      if (|req_valid) grant = gidx ? 2'b10 : 2'b01;
   end
endmodule

// File: rtl/arith_arbiter.sv
// Shares one combinational arith_unit between two valid/ready requesters,
// holding operands for EXEC_CYCLES before capturing and returning the result.
module arith_arbiter
   import arith_pkg::*;
#(
   parameter int EXEC_CYCLES = 1,
   parameter int CNT_W       = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0][DW-1:0]  req_a,
   input  logic [NREQ-1:0][DW-1:0]  req_b,
   input  logic [NREQ-1:0][OPW-1:0] req_op,
   output logic [NREQ-1:0]          resp_valid,
   input  logic [NREQ-1:0]          resp_ready,
   output logic [RW-1:0]            resp_data,
   output logic [DW-1:0]            au_in_a,
   output logic [DW-1:0]            au_in_b,
   output logic [OPW-1:0]           au_opcode,
   input  logic [RW-1:0]            au_out_arith,
   output logic                     busy,
   output logic [CNT_W-1:0]         ops_done
);
   state_t          state, state_nxt;
   logic            owner, last_grant, gidx;
   logic [NREQ-1:0] grant;
   logic [3:0]      exec_cnt;
   logic            hs_req, hs_resp;

   rr_arb2 u_arb (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .gidx       (gidx)
   );

   assign req_ready = (state == IDLE) ? grant : '0;
   assign hs_req    = |(req_valid & req_ready);
   assign hs_resp   = |(resp_valid & resp_ready);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs_req) state_nxt = EXEC;
         EXEC:    if (exec_cnt == '0) state_nxt = RESP;
         RESP:    if (hs_resp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // au_* only load on a request handshake so the shared unit sees no toggling while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         au_in_a    <= '0;
         au_in_b    <= '0;
         au_opcode  <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         exec_cnt   <= '0;
         resp_data  <= '0;
         resp_valid <= '0;
         ops_done   <= '0;
      end else begin
         case (state)
            IDLE: if (hs_req) begin
               au_in_a    <= req_a[gidx];
               au_in_b    <= req_b[gidx];
               au_opcode  <= req_op[gidx];
               owner      <= gidx;
               last_grant <= gidx;
               exec_cnt   <= 4'(EXEC_CYCLES - 1);
            end
            EXEC: if (exec_cnt == '0) begin
               resp_data  <= au_out_arith;
               resp_valid <= owner ? 2'b10 : 2'b01;
            end else begin
               exec_cnt <= exec_cnt - 4'd1;
            end
            RESP: if (hs_resp) begin
               resp_valid <= '0;
               if (ops_done != {CNT_W{1'b1}}) ops_done <= ops_done + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter with an adder stub standing in for arith_unit.
module tb_arith_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // instance A: EXEC_CYCLES=1, CNT_W=16
   logic [1:0]       req_valid, req_ready, resp_valid, resp_ready;
   logic [1:0][15:0] req_a, req_b;
   logic [1:0][2:0]  req_op;
   logic [31:0]      resp_data, au_out;
   logic [15:0]      au_in_a, au_in_b, ops_done;
   logic [2:0]       au_opcode;
   logic             busy;

   // instance B: EXEC_CYCLES=4, CNT_W=2
   logic [1:0]       s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
   logic [1:0][15:0] s_req_a, s_req_b;
   logic [1:0][2:0]  s_req_op;
   logic [31:0]      s_resp_data, s_au_out;
   logic [15:0]      s_au_in_a, s_au_in_b;
   logic [1:0]       s_ops_done;
   logic [2:0]       s_au_opcode;
   logic             s_busy;

   assign au_out   = 32'(au_in_a) + 32'(au_in_b);
   assign s_au_out = 32'(s_au_in_a) + 32'(s_au_in_b);

   arith_arbiter #(.EXEC_CYCLES(1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_op(req_op), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .au_in_a(au_in_a),
      .au_in_b(au_in_b), .au_opcode(au_opcode), .au_out_arith(au_out),
      .busy(busy), .ops_done(ops_done)
   );

   arith_arbiter #(.EXEC_CYCLES(4), .CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
      .req_a(s_req_a), .req_b(s_req_b), .req_op(s_req_op), .resp_valid(s_resp_valid),
      .resp_ready(s_resp_ready), .resp_data(s_resp_data), .au_in_a(s_au_in_a),
      .au_in_b(s_au_in_b), .au_opcode(s_au_opcode), .au_out_arith(s_au_out),
      .busy(s_busy), .ops_done(s_ops_done)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      tick();
      tick();
      #2 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
      s_req_valid = '0; s_resp_ready = '0; s_req_a = '0; s_req_b = '0; s_req_op = '0;
      tick();
      tick();
      chk("rst req_ready", 32'(req_ready), 0);
      chk("rst resp_valid", 32'(resp_valid), 0);
      chk("rst resp_data", resp_data, 0);
      chk("rst au_in_a", 32'(au_in_a), 0);
      chk("rst au_in_b", 32'(au_in_b), 0);
      chk("rst au_opcode", 32'(au_opcode), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst ops_done", 32'(ops_done), 0);
      #2 rst_n = 1'b1;
      tick();

      // single op
      req_a[0] = 16'h0004; req_b[0] = 16'h0007; req_op[0] = 3'd0;
      req_valid = 2'b01; resp_ready = 2'b01;
      #1 chk("single req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = '0;
      chk("single au_in_a", 32'(au_in_a), 32'h4);
      chk("single au_in_b", 32'(au_in_b), 32'h7);
      chk("single busy", 32'(busy), 1);
      chk("single early resp_valid", 32'(resp_valid), 0);
      tick();
      chk("single resp_valid", 32'(resp_valid), 32'h1);
      chk("single resp_data", resp_data, 32'hB);
      tick();
      chk("single resp_valid drop", 32'(resp_valid), 0);
      chk("single ops_done", 32'(ops_done), 1);
      chk("single busy idle", 32'(busy), 0);

      // contention from reset
      do_reset();
      req_a[0] = 16'd1; req_b[0] = 16'd1; req_a[1] = 16'd2; req_b[1] = 16'd2;
      req_valid = 2'b11; resp_ready = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1 chk($sformatf("cont grant %0d", i), 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
         tick();
         tick();
         chk($sformatf("cont resp_valid %0d", i), 32'(resp_valid), (i % 2) ? 32'h2 : 32'h1);
         chk($sformatf("cont resp_data %0d", i), resp_data, (i % 2) ? 32'h4 : 32'h2);
         tick();
      end
      chk("cont ops_done", 32'(ops_done), 4);

      // backpressure: req0 in flight while req1 waits
      req_valid = 2'b01; resp_ready = 2'b00;
      #1 chk("bp grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b10; req_a[1] = 16'd5; req_b[1] = 16'd6;
      tick();
      chk("bp resp_valid rise", 32'(resp_valid), 32'h1);
      chk("bp resp_data rise", resp_data, 32'h2);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("bp hold valid %0d", i), 32'(resp_valid), 32'h1);
         chk($sformatf("bp hold data %0d", i), resp_data, 32'h2);
         chk($sformatf("bp hold ready %0d", i), 32'(req_ready), 0);
      end
      resp_ready = 2'b11;
      #1 chk("bp ready before hs", 32'(req_ready), 0);
      tick();
      chk("bp resp_valid done", 32'(resp_valid), 0);
      chk("bp req1 ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      chk("bp req1 au_in_a", 32'(au_in_a), 32'h5);
      tick();
      chk("bp req1 resp_valid", 32'(resp_valid), 32'h2);
      chk("bp req1 resp_data", resp_data, 32'hB);
      tick();

      // reset mid-op
      req_a[0] = 16'd9; req_b[0] = 16'd9; req_valid = 2'b01;
      tick();
      req_valid = '0;
      chk("mid busy", 32'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid rst busy", 32'(busy), 0);
      chk("mid rst au_in_a", 32'(au_in_a), 0);
      chk("mid rst resp_valid", 32'(resp_valid), 0);
      chk("mid rst ops_done", 32'(ops_done), 0);
      tick();
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mid no resp %0d", i), 32'(resp_valid), 0);
      end
      req_valid = 2'b10;
      #1 chk("post rst req1 only", 32'(req_ready), 32'h2);
      req_valid = 2'b11;
      #1 chk("post rst both", 32'(req_ready), 32'h1);
      req_valid = '0;
      tick();

      // latency and saturation on the EXEC_CYCLES=4, CNT_W=2 instance
      s_resp_ready = 2'b01;
      s_req_a[0] = 16'hFFFF; s_req_b[0] = 16'h0001; s_req_valid = 2'b01;
      #1 chk("lat req_ready", 32'(s_req_ready), 32'h1);
      tick();
      s_req_valid = '0;
      for (int c = 1; c < 5; c++) begin
         chk($sformatf("lat no resp c%0d", c), 32'(s_resp_valid), 0);
         tick();
      end
      chk("lat resp_valid", 32'(s_resp_valid), 32'h1);
      chk("lat resp_data", s_resp_data, 32'h00010000);
      tick();
      chk("sat ops_done 1", 32'(s_ops_done), 1);
      for (int i = 1; i < 5; i++) begin
         s_req_a[0] = 16'd1; s_req_b[0] = 16'(i); s_req_valid = 2'b01;
         tick();
         s_req_valid = '0;
         repeat (4) tick();
         chk($sformatf("sat resp_data %0d", i), s_resp_data, 32'(i + 1));
         tick();
         chk($sformatf("sat ops_done %0d", i + 1), 32'(s_ops_done), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
